mem2p_be_pipe: RTL and testbench
================================

MEM2P_BE_PIPE -- requirements
Module: mem2p_be_pipe

Interface
REQ-001 Parameter W, default 32, data word width in bits; SHALL be a multiple of BW.
REQ-002 Parameter D, default 128, depth in words; any value >= 2, not restricted to powers of two.
REQ-003 Parameter BW, default 8, byte-lane width; NB = W/BW lanes; DW = $clog2(D) as localparams.
REQ-004 Parameter RLAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 Parameter RDW_MODE, default RDW_OLD, same-address read-during-write result (RDW_OLD / RDW_NEW).
REQ-006 Parameter CLR_ON_RST, default 1, clear whole array to zero after reset when 1.
REQ-007 Ports; one clock, reset synchronous and active-high:
  clk      in   1    sole clock, all logic on rising edge
  rst      in   1    synchronous active-high reset
  we1      in   1    port-1 write enable
  be1      in   NB   per-lane byte enables for port 1
  addr1    in   DW   port-1 write address
  din1     in   W    port-1 write data
  re2      in   1    port-2 read enable
  addr2    in   DW   port-2 read address
  dout2    out  W    registered read data
  rvalid2  out  1    one-cycle pulse marking new dout2
  ready    out  1    high when array accepts reads/writes

Function
REQ-008 Write: at edge t with ready=1, we1=1, addr1<D, lanes with be1[i]=1 take din1 lane i; other lanes keep their value.
REQ-009 Read: re2=1 with ready=1 at edge t; dout2 valid and rvalid2=1 at edge t+RLAT, for exactly one cycle per request.
REQ-010 Back-to-back reads every cycle SHALL be accepted; throughput one read per cycle at either RLAT.
REQ-011 dout2 SHALL hold its last value when no read completes; only rvalid2 marks new data.
REQ-012 Same-cycle same-address read and write: RDW_OLD returns pre-write word; RDW_NEW returns merged word (enabled lanes from din1, others old).
REQ-013 Out-of-range addr1 (>= D): write dropped, no array change; out-of-range addr2: dout2=0 with rvalid2=1 at normal latency.
REQ-014 While ready=0, we1 and re2 SHALL be ignored; no rvalid2 is generated for them.
REQ-015 Clear sequencer states: CLEAR, READY. During rst: state CLEAR if CLR_ON_RST=1, else READY; clear counter=0.
REQ-016 CLEAR: one word per cycle written to zero, addresses 0..D-1 ascending; after writing D-1, READY next cycle; CLEAR occupies exactly D cycles after rst deasserts.
REQ-017 READY SHALL persist until rst; rst during CLEAR restarts the clear at address 0.
REQ-018 CLR_ON_RST=0: ready=1 in the first cycle after rst deasserts; array contents undefined until written.

Reset
REQ-019 While rst=1: ready=0, rvalid2=0, dout2=0, all read-pipeline valid bits cleared.
REQ-020 A read in flight when rst asserts SHALL produce no rvalid2 pulse.
REQ-021 Array contents are not reset directly; zeroing is only via the REQ-016 sequence.

Structure
REQ-022 Shared package mem_pkg SHALL hold the rdw_mode_e enum (RDW_OLD, RDW_NEW) and clear-state enum clr_state_e (CLEAR, READY).
REQ-023 Clear counter and state SHALL live in sub-module mem_clr_ctrl (outputs: clear-write enable, clear address, ready).
REQ-024 Array SHALL infer block RAM: one write port (muxed between port 1 and clear), one synchronous read port; RLAT=2 adds one output register.

Verification
REQ-025 D=128, CLR_ON_RST=1: deassert rst at cycle 0 -> ready rises at cycle 128; reads of addr 0, 64, 127 return 0.
REQ-026 Write 0xDEADBEEF to addr 5 with be1=4'b1111, then be1=4'b0010 din1=0x0000AA00 -> read addr 5 returns 0xDEADAAEF, rvalid2 after RLAT cycles (check RLAT=1 and 2).
REQ-027 addr 9 holds 0x11111111; same cycle write 0x22222222 be1=4'b1111 and read addr 9 -> RDW_OLD returns 0x11111111, RDW_NEW returns 0x22222222.
REQ-028 D=100: write addr 100 then read addr 100 -> dout2=0, rvalid2=1; addr 99 unchanged.
REQ-029 Assert rst at clear counter 50 for one cycle -> ready rises exactly 128 cycles after rst deasserts; pending read issues no rvalid2.
REQ-030 re2=1 for 16 consecutive cycles on addrs 0..15 -> 16 consecutive rvalid2 pulses with data in order.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the two-port byte-enable memory: read-during-write
// behaviour and the power-up clear sequencer states.
package mem_pkg;
  typedef enum logic {RDW_OLD = 1'b0, RDW_NEW = 1'b1} rdw_mode_e;
  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} clr_state_e;
endpackage

// File: rtl/mem_clr_ctrl.sv
// Post-reset clear sequencer: walks addresses 0..D-1 writing zero, then
// holds READY until the next reset. State is exported for observation.
module mem_clr_ctrl
  import mem_pkg::*;
#(
  parameter int D          = 128,
  parameter int CLR_ON_RST = 1,
  localparam int DW        = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [DW-1:0] clr_addr,
  output logic          ready,
  output clr_state_e    state
);
  clr_state_e    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLR_ON_RST != 0) ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    ready   = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = !rst;
        if (cnt_q == DW'(D - 1)) state_d = READY;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      READY: ready = !rst;
    endcase
  end

  assign clr_addr = cnt_q;
  assign state    = state_q;
endmodule

// File: rtl/mem2p_be_pipe.sv
// Simple dual-port RAM: port 1 writes with byte enables, port 2 reads with
// a 1- or 2-cycle pipeline; array is zeroed by a sequencer after reset.
module mem2p_be_pipe
  import mem_pkg::*;
#(
  parameter int        W          = 32,
  parameter int        D          = 128,
  parameter int        BW         = 8,
  parameter int        RLAT       = 1,
  parameter rdw_mode_e RDW_MODE   = RDW_OLD,
  parameter int        CLR_ON_RST = 1,
  localparam int       NB         = W / BW,
  localparam int       DW         = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we1,
  input  logic [NB-1:0] be1,
  input  logic [DW-1:0] addr1,
  input  logic [W-1:0]  din1,
  input  logic          re2,
  input  logic [DW-1:0] addr2,
  output logic [W-1:0]  dout2,
  output logic          rvalid2,
  output logic          ready
);
  localparam logic [DW:0] DEPTH = D[DW:0];

  logic          clr_we;
  logic [DW-1:0] clr_addr;
  clr_state_e    clr_state;

  mem_clr_ctrl #(.D(D), .CLR_ON_RST(CLR_ON_RST)) u_clr (
    .clk(clk), .rst(rst), .clr_we(clr_we), .clr_addr(clr_addr),
    .ready(ready), .state(clr_state)
  );

  always @(posedge clk) if (!rst) assert ((clr_state == READY) == ready);

  // Handshake: a request is taken on any edge where ready=1 and we1/re2=1;
  // nothing is taken while ready=0. Each taken read yields one rvalid2 pulse
  // RLAT edges later, and dout2 changes only alongside that pulse.
  logic          wr_en, rd_fire, rd_in_range;
  logic [DW-1:0] wr_addr;
  logic [NB-1:0] wr_be;
  logic [W-1:0]  wr_data;

  always_comb begin
    rd_in_range = {1'b0, addr2} < DEPTH;
    rd_fire     = ready & re2;
    wr_en       = clr_we | (ready & we1 & ({1'b0, addr1} < DEPTH));
    wr_addr     = clr_we ? clr_addr : addr1;
    wr_be       = clr_we ? {NB{1'b1}} : be1;
    wr_data     = clr_we ? '0 : din1;
  end

  logic [W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) mem[wr_addr][i*BW +: BW] <= wr_data[i*BW +: BW];
  end

  // Stage 1 keeps the raw RAM word plus the colliding write, so the
  // RDW_NEW merge happens after the RAM output register.
  logic          v1, oor1, hit1;
  logic [NB-1:0] wbe1;
  logic [W-1:0]  wdat1, ram_q, rd_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      oor1  <= 1'b0;
      hit1  <= 1'b0;
      wbe1  <= '0;
      wdat1 <= '0;
      ram_q <= '0;
    end else begin
      v1 <= rd_fire;
      if (rd_fire) begin
        oor1  <= !rd_in_range;
        hit1  <= (RDW_MODE == RDW_NEW) && wr_en && (wr_addr == addr2);
        wbe1  <= be1;
        wdat1 <= din1;
        if (rd_in_range) ram_q <= mem[addr2];
      end
    end
  end

  always_comb begin
    rd_word = ram_q;
    for (int i = 0; i < NB; i++)
      if (hit1 && wbe1[i]) rd_word[i*BW +: BW] = wdat1[i*BW +: BW];
    if (oor1) rd_word = '0;
  end

  logic [W-1:0] dout_sel;
  logic         vld_sel;

  generate
    if (RLAT == 2) begin : g_lat2
      logic [W-1:0] dout_q;
      logic         v2;
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
          v2     <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) dout_q <= rd_word;
        end
      end
      assign dout_sel = dout_q;
      assign vld_sel  = v2;
    end else begin : g_lat1
      assign dout_sel = rd_word;
      assign vld_sel  = v1;
    end
  endgenerate

  // Gating with rst suppresses a pulse already in flight when reset arrives.
  assign dout2   = rst ? '0 : dout_sel;
  assign rvalid2 = vld_sel & !rst;
endmodule

// File: tb/tb_mem2p_be_pipe.sv
// Two instances share stimulus: A = D128/RLAT1/RDW_OLD, B = D100/RLAT2/RDW_NEW.
// Reads push hand-computed expectations; negedge monitors pop and compare.
module tb_mem2p_be_pipe;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we1 = 1'b0, re2 = 1'b0;
  logic [3:0]  be1 = '0;
  logic [6:0]  addr1 = '0, addr2 = '0;
  logic [31:0] din1 = '0;
  logic [31:0] dout_a, dout_b;
  logic        rv_a, rv_b, rdy_a, rdy_b;

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [31:0] exp_a_q[$], exp_b_q[$];
  int          due_a_q[$], due_b_q[$];
  logic [31:0] last_a = '0, last_b = '0;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem2p_be_pipe #(.D(128), .RLAT(1), .RDW_MODE(RDW_OLD)) dut_a (
    .clk(clk), .rst(rst), .we1(we1), .be1(be1), .addr1(addr1), .din1(din1),
    .re2(re2), .addr2(addr2), .dout2(dout_a), .rvalid2(rv_a), .ready(rdy_a)
  );

  mem2p_be_pipe #(.D(100), .RLAT(2), .RDW_MODE(RDW_NEW)) dut_b (
    .clk(clk), .rst(rst), .we1(we1), .be1(be1), .addr1(addr1), .din1(din1),
    .re2(re2), .addr2(addr2), .dout2(dout_b), .rvalid2(rv_b), .ready(rdy_b)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst) begin
      last_a = '0;
      check("a reset dout2", dout_a, 32'h0);
      check("a reset rvalid2", {31'b0, rv_a}, 32'h0);
      check("a reset ready", {31'b0, rdy_a}, 32'h0);
    end else if (rv_a) begin
      if (exp_a_q.size() == 0) check("a unexpected rvalid2", 32'h1, 32'h0);
      else begin
        check("a dout2", dout_a, exp_a_q[0]);
        check("a latency", cyc, due_a_q[0]);
        last_a = exp_a_q.pop_front();
        void'(due_a_q.pop_front());
      end
    end else check("a dout2 hold", dout_a, last_a);
  end

  always @(negedge clk) begin
    if (rst) begin
      last_b = '0;
      check("b reset dout2", dout_b, 32'h0);
      check("b reset rvalid2", {31'b0, rv_b}, 32'h0);
      check("b reset ready", {31'b0, rdy_b}, 32'h0);
    end else if (rv_b) begin
      if (exp_b_q.size() == 0) check("b unexpected rvalid2", 32'h1, 32'h0);
      else begin
        check("b dout2", dout_b, exp_b_q[0]);
        check("b latency", cyc, due_b_q[0]);
        last_b = exp_b_q.pop_front();
        void'(due_b_q.pop_front());
      end
    end else check("b dout2 hold", dout_b, last_b);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we1 = 1'b0;
    re2 = 1'b0;
  endtask

  task automatic issue(bit w, logic [6:0] wa, logic [3:0] be, logic [31:0] d,
                       bit r, logic [6:0] ra, logic [31:0] ea, logic [31:0] eb);
    we1 = w; addr1 = wa; be1 = be; din1 = d;
    re2 = r; addr2 = ra;
    step();
    if (r) begin
      exp_a_q.push_back(ea); due_a_q.push_back(cyc);
      exp_b_q.push_back(eb); due_b_q.push_back(cyc + 1);
    end
    idle();
  endtask

  task automatic wr(logic [6:0] a, logic [3:0] be, logic [31:0] d);
    issue(1'b1, a, be, d, 1'b0, 7'd0, 32'h0, 32'h0);
  endtask

  task automatic rd(logic [6:0] a, logic [31:0] ea, logic [31:0] eb);
    issue(1'b0, 7'd0, 4'h0, 32'h0, 1'b1, a, ea, eb);
  endtask

  // Counts edges after reset release until each ready goes high; optionally
  // pokes writes/reads at addr 20 while still clearing (must be ignored).
  task automatic measure_ready(string tag, bit poke);
    int na = -1, nb = -1;
    for (int n = 1; n <= 300 && (na < 0 || nb < 0); n++) begin
      if (poke && n >= 40 && n < 50) begin
        we1 = 1'b1; addr1 = 7'd20; be1 = 4'hF; din1 = 32'hFFFF_FFFF;
        re2 = 1'b1; addr2 = 7'd20;
      end else idle();
      step();
      if (rdy_a && na < 0) na = n;
      if (rdy_b && nb < 0) nb = n;
    end
    idle();
    check({tag, " a clear cycles"}, na, 128);
    check({tag, " b clear cycles"}, nb, 100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    measure_ready("power-up", 1'b0);

    rst = 1'b1; step(); rst = 1'b0;
    repeat (50) step();
    rst = 1'b1; step(); rst = 1'b0;
    measure_ready("restart", 1'b0);

    rd(7'd0, 32'h0, 32'h0);
    rd(7'd64, 32'h0, 32'h0);
    rd(7'd127, 32'h0, 32'h0);

    wr(7'd5, 4'hF, 32'hDEAD_BEEF);
    wr(7'd5, 4'h2, 32'h0000_AA00);
    rd(7'd5, 32'hDEAD_AAEF, 32'hDEAD_AAEF);
    wr(7'd5, 4'h0, 32'hFFFF_FFFF);
    rd(7'd5, 32'hDEAD_AAEF, 32'hDEAD_AAEF);

    wr(7'd9, 4'hF, 32'h1111_1111);
    issue(1'b1, 7'd9, 4'hF, 32'h2222_2222, 1'b1, 7'd9, 32'h1111_1111, 32'h2222_2222);
    rd(7'd9, 32'h2222_2222, 32'h2222_2222);

    wr(7'd10, 4'hF, 32'hAABB_CCDD);
    issue(1'b1, 7'd10, 4'h5, 32'h1122_3344, 1'b1, 7'd10, 32'hAABB_CCDD, 32'hAA22_CC44);
    rd(7'd10, 32'hAA22_CC44, 32'hAA22_CC44);

    wr(7'd99, 4'hF, 32'h9999_9999);
    wr(7'd100, 4'hF, 32'h5555_5555);
    rd(7'd100, 32'h5555_5555, 32'h0);
    rd(7'd99, 32'h9999_9999, 32'h9999_9999);

    for (int i = 0; i < 16; i++) wr(7'(i), 4'hF, 32'hC0DE_0000 | 32'(i));
    for (int i = 0; i < 16; i++) rd(7'(i), 32'hC0DE_0000 | 32'(i), 32'hC0DE_0000 | 32'(i));
    idle();
    repeat (3) step();

    // read in flight when reset arrives must not complete
    re2 = 1'b1; addr2 = 7'd5;
    step();
    re2 = 1'b0; rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    measure_ready("in-flight", 1'b1);
    rd(7'd20, 32'h0, 32'h0);
    rd(7'd5, 32'h0, 32'h0);

    repeat (5) step();
    check("a queue drained", exp_a_q.size(), 32'h0);
    check("b queue drained", exp_b_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
